// File: rtl/loong_pkg.sv
// Shared types and frame constants for the LOONG encryptor front end.
package loong_pkg;

    typedef logic [3:0]     nibble_t;
    typedef nibble_t [15:0] nibble_arr_t;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        TRAILER,
        LAUNCH
    } loader_state_t;

    localparam logic [7:0]  LOONG_HDR     = 8'hAA;
    localparam logic [7:0]  LOONG_TRL     = 8'hFF;
    localparam int unsigned LOONG_NIBBLES = 16;

endpackage

// File: rtl/loong_rx_timeout.sv
// Inter-byte watchdog: pulses expired when TIMEOUT_CYCLES consecutive cycles pass without a kick.
module loong_rx_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TERM = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    // Combinational so a kick in the terminal cycle suppresses the pulse (the byte wins).
    assign expired = (TIMEOUT_CYCLES != 0) && enable && !kick && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!enable || kick || expired) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/loong_frame_loader.sv
// Parses AA / 16 payload / FF frames from the UART byte stream into double-buffered
// plaintext and round-key nibble arrays, then pulses do_loong to start the encryptor.
module loong_frame_loader
    import loong_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE       = LOONG_HDR,
    parameter logic [7:0]  TRL_BYTE       = LOONG_TRL,
    parameter int unsigned NIBBLES        = LOONG_NIBBLES,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [3:0] plaintext [NIBBLES-1:0],
    output logic [3:0] round_key [NIBBLES-1:0],
    output logic       do_loong,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    loader_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    nibble_t       shadow_pt_q  [NIBBLES-1:0];
    nibble_t       shadow_pt_d  [NIBBLES-1:0];
    nibble_t       shadow_key_q [NIBBLES-1:0];
    nibble_t       shadow_key_d [NIBBLES-1:0];
    nibble_t       plaintext_q  [NIBBLES-1:0];
    nibble_t       plaintext_d  [NIBBLES-1:0];
    nibble_t       round_key_q  [NIBBLES-1:0];
    nibble_t       round_key_d  [NIBBLES-1:0];
    logic          do_loong_q, do_loong_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          in_frame;
    logic          expired;

    assign in_frame = (state_q == PAYLOAD) || (state_q == TRAILER);

    loong_rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .enable (in_frame),
        .kick   (rx_valid),
        .expired(expired)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_pt_d  = shadow_pt_q;
        shadow_key_d = shadow_key_q;
        plaintext_d  = plaintext_q;
        round_key_d  = round_key_q;
        frame_cnt_d  = frame_cnt_q;
        frame_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_valid && (rx_byte == HDR_BYTE)) begin
                    state_d = PAYLOAD;
                    idx_d   = '0;
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    shadow_pt_d[idx_q]  = rx_byte[3:0];
                    shadow_key_d[idx_q] = rx_byte[7:4];
                    if (idx_q == LAST_IDX) begin
                        state_d = TRAILER;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (expired) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            TRAILER: begin
                if (rx_valid) begin
                    if (rx_byte == TRL_BYTE) begin
                        state_d     = LAUNCH;
                        plaintext_d = shadow_pt_q;
                        round_key_d = shadow_key_q;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end
                end else if (expired) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            LAUNCH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d == PAYLOAD) || (state_d == TRAILER);
        do_loong_d = (state_d == LAUNCH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            shadow_pt_q  <= '{default: '0};
            shadow_key_q <= '{default: '0};
            plaintext_q  <= '{default: '0};
            round_key_q  <= '{default: '0};
            frame_cnt_q  <= '0;
            do_loong_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_pt_q  <= shadow_pt_d;
            shadow_key_q <= shadow_key_d;
            plaintext_q  <= plaintext_d;
            round_key_q  <= round_key_d;
            frame_cnt_q  <= frame_cnt_d;
            do_loong_q   <= do_loong_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign plaintext = plaintext_q;
    assign round_key = round_key_q;
    assign do_loong  = do_loong_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_loong_frame_loader.sv
// Directed bench for loong_frame_loader with a launch scoreboard.
`timescale 1ns/1ps
module tb_loong_frame_loader;
    import loong_pkg::*;

    localparam int unsigned N  = LOONG_NIBBLES;
    localparam int unsigned TO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [3:0] plaintext [N-1:0];
    logic [3:0] round_key [N-1:0];
    logic       do_loong, frame_err, busy;
    logic [7:0] frame_cnt;

    int checks = 0;
    int failures = 0;
    int dl_cnt = 0;
    int fe_cnt = 0;

    typedef struct {
        logic [63:0] pt;
        logic [63:0] key;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb [$];
    logic [63:0] last_pt = '0;
    logic [63:0] last_key = '0;
    logic [7:0]  exp_cnt = '0;
    logic [7:0]  pl [16];

    loong_frame_loader #(
        .HDR_BYTE      (8'hAA),
        .TRL_BYTE      (8'hFF),
        .NIBBLES       (N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .plaintext(plaintext),
        .round_key(round_key),
        .do_loong (do_loong),
        .frame_err(frame_err),
        .busy     (busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [3:0] a [N-1:0]);
        logic [63:0] r;
        for (int k = 0; k < int'(N); k++) r[k*4 +: 4] = a[k];
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            exp_t e;
            if (do_loong || frame_err) check("pulse_exclusive", {63'd0, do_loong & frame_err}, 64'd0);
            if (frame_err) fe_cnt++;
            if (do_loong) begin
                dl_cnt++;
                check("sb_has_entry", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("launch_pt", pk(plaintext), e.pt);
                    check("launch_key", pk(round_key), e.key);
                    check("launch_cnt", {56'd0, frame_cnt}, {56'd0, e.cnt});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_frame(input logic [7:0] p [16]);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            e.pt[k*4 +: 4]  = p[k][3:0];
            e.key[k*4 +: 4] = p[k][7:4];
        end
        exp_cnt  = exp_cnt + 8'd1;
        e.cnt    = exp_cnt;
        last_pt  = e.pt;
        last_key = e.key;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] p [16], input logic [7:0] trl);
        send_byte(8'hAA);
        for (int k = 0; k < 16; k++) send_byte(p[k]);
        send_byte(trl);
        idle(2);
    endtask

    initial begin
        int dl0, fe0;

        // reset state
        @(negedge clk);
        idle(2);
        check("rst_pt", pk(plaintext), 64'd0);
        check("rst_key", pk(round_key), 64'd0);
        check("rst_cnt", {56'd0, frame_cnt}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_pulses", {62'd0, do_loong, frame_err}, 64'd0);
        reset = 1'b1;
        idle(2);

        // good frame 0x10..0x1F with exact latency
        for (int k = 0; k < 16; k++) pl[k] = 8'h10 + 8'(k);
        expect_frame(pl);
        dl0 = dl_cnt;
        send_byte(8'hAA);
        check("busy_after_hdr", {63'd0, busy}, 64'd1);
        for (int k = 0; k < 16; k++) send_byte(pl[k]);
        check("busy_in_trailer", {63'd0, busy}, 64'd1);
        check("no_launch_before_trl", {63'd0, do_loong}, 64'd0);
        send_byte(8'hFF);
        check("launch_n_plus_1", {63'd0, do_loong}, 64'd1);
        check("busy_falls", {63'd0, busy}, 64'd0);
        check("good_pt_value", pk(plaintext), 64'hFEDC_BA98_7654_3210);
        check("good_key_value", pk(round_key), 64'h1111_1111_1111_1111);
        idle(1);
        check("launch_single", {63'd0, do_loong}, 64'd0);
        idle(2);
        check("good_dl_count", 64'(dl_cnt - dl0), 64'd1);
        check("good_cnt", {56'd0, frame_cnt}, 64'd1);

        // bad trailer
        for (int k = 0; k < 16; k++) pl[k] = 8'h5A;
        dl0 = dl_cnt; fe0 = fe_cnt;
        send_frame(pl, 8'h00);
        check("bad_fe", 64'(fe_cnt - fe0), 64'd1);
        check("bad_no_dl", 64'(dl_cnt - dl0), 64'd0);
        check("bad_pt_hold", pk(plaintext), last_pt);
        check("bad_key_hold", pk(round_key), last_key);
        check("bad_cnt_hold", {56'd0, frame_cnt}, {56'd0, exp_cnt});

        // leading noise, then payload full of header values
        dl0 = dl_cnt; fe0 = fe_cnt;
        send_byte(8'h33);
        send_byte(8'hFF);
        idle(1);
        check("noise_ignored", {63'd0, busy}, 64'd0);
        for (int k = 0; k < 16; k++) pl[k] = 8'hAA;
        expect_frame(pl);
        send_frame(pl, 8'hFF);
        check("noise_dl", 64'(dl_cnt - dl0), 64'd1);
        check("noise_fe", 64'(fe_cnt - fe0), 64'd0);
        check("transp_pt", pk(plaintext), {16{4'hA}});

        // timeout exactly TO cycles after the last byte
        fe0 = fe_cnt;
        send_byte(8'hAA);
        for (int k = 1; k <= 5; k++) send_byte(8'(k));
        repeat (TO - 1) @(posedge clk);
        @(negedge clk);
        check("to_not_early", {63'd0, frame_err}, 64'd0);
        check("to_busy_held", {63'd0, busy}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("to_fires", {63'd0, frame_err}, 64'd1);
        check("to_idle", {63'd0, busy}, 64'd0);
        check("to_pt_hold", pk(plaintext), last_pt);
        idle(2);
        check("to_fe_count", 64'(fe_cnt - fe0), 64'd1);
        dl0 = dl_cnt;
        for (int k = 0; k < 16; k++) pl[k] = 8'($urandom);
        expect_frame(pl);
        send_frame(pl, 8'hFF);
        check("after_to_dl", 64'(dl_cnt - dl0), 64'd1);

        // byte coincident with terminal count is accepted
        dl0 = dl_cnt; fe0 = fe_cnt;
        for (int k = 0; k < 16; k++) pl[k] = 8'($urandom);
        expect_frame(pl);
        send_byte(8'hAA);
        for (int k = 0; k < 3; k++) send_byte(pl[k]);
        idle(TO - 1);
        for (int k = 3; k < 16; k++) send_byte(pl[k]);
        send_byte(8'hFF);
        idle(2);
        check("coinc_no_fe", 64'(fe_cnt - fe0), 64'd0);
        check("coinc_dl", 64'(dl_cnt - dl0), 64'd1);

        // header during LAUNCH is dropped
        dl0 = dl_cnt;
        for (int k = 0; k < 16; k++) pl[k] = 8'($urandom);
        expect_frame(pl);
        send_byte(8'hAA);
        for (int k = 0; k < 16; k++) send_byte(pl[k]);
        send_byte(8'hFF);
        send_byte(8'hAA);
        check("launch_drop_busy", {63'd0, busy}, 64'd0);
        for (int k = 0; k < 16; k++) send_byte(8'h11);
        send_byte(8'hFF);
        idle(2);
        check("launch_drop_dl", 64'(dl_cnt - dl0), 64'd1);

        // reset mid-frame
        dl0 = dl_cnt; fe0 = fe_cnt;
        send_byte(8'hAA);
        for (int k = 1; k <= 8; k++) send_byte(8'(k));
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        last_pt = '0; last_key = '0; exp_cnt = '0;
        check("mid_rst_pt", pk(plaintext), 64'd0);
        check("mid_rst_key", pk(round_key), 64'd0);
        check("mid_rst_cnt", {56'd0, frame_cnt}, 64'd0);
        for (int k = 9; k <= 16; k++) send_byte(8'(k));
        send_byte(8'hFF);
        idle(2);
        check("mid_rst_no_pulse", 64'(dl_cnt - dl0 + fe_cnt - fe0), 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_pt_hold", pk(plaintext), 64'd0);

        // frame counter wraps after 256 good frames
        dl0 = dl_cnt;
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 16; k++) pl[k] = 8'($urandom);
            expect_frame(pl);
            send_frame(pl, 8'hFF);
        end
        check("wrap_dl", 64'(dl_cnt - dl0), 64'd256);
        check("wrap_cnt", {56'd0, frame_cnt}, 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
